// File: rtl/trng_arbiter.sv
// trng_arbiter: round-robin arbiter that shares one TRNG among NREQ requesters.
// Each winner gets a single 32-bit word. The TRNG handshake is level based:
// trng_request is held high until trng_ready, then dropped until ready clears.
// Optional macro TRNG_ARB_HEALTH_EN adds a word health check. Stuck-at words
// and repeated words are rejected, the request is retried for the same winner,
// and a sticky alarm is raised after MAX_RETRY consecutive failures.
module trng_arbiter #(
    parameter int NREQ      = 3,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] rnd_valid,
    output logic [31:0]     rnd_data,
    output logic            timeout_err,
    output logic            health_fail,
    output logic            trng_request,
    input  logic [31:0]     trng_random_number,
    input  logic            trng_ready
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW-1:0] LAST_RESET = IDXW'(NREQ - 1);
    localparam logic [15:0]     WAIT_LIMIT = 16'(TIMEOUT - 1);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535 || MAX_RETRY < 1) begin : g_param_check
        $error("trng_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        DELIVER,
        RELEASE
    } state_t;

    state_t          state;
    logic [IDXW-1:0] last_winner;
    logic [IDXW-1:0] winner;
    logic [IDXW-1:0] rr_pick;
    logic            rr_found;
    int              rr_idx;
    logic [15:0]     wait_cnt;

`ifdef TRNG_ARB_HEALTH_EN
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_cnt;
    logic [31:0]   prev_word;
    logic          word_bad;
    logic          retry_pending;
    logic          health_fail_q;
    logic          word_ok;

    // A word is acceptable when it is not stuck-at and differs from the last delivered word
    assign word_ok = (trng_random_number != 32'h0000_0000) &&
                     (trng_random_number != 32'hFFFF_FFFF) &&
                     (trng_random_number != prev_word);
    assign health_fail = health_fail_q;
`else
    assign health_fail = 1'b0;
`endif

    // Round-robin search beginning one past the last successful winner
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = int'(last_winner) + i;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!rr_found && req[IDXW'(rr_idx)]) begin
                rr_found = 1'b1;
                rr_pick  = IDXW'(rr_idx);
            end
        end
    end

    // Transaction FSM; every output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            rnd_valid    <= '0;
            rnd_data     <= '0;
            trng_request <= 1'b0;
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
            winner       <= '0;
            last_winner  <= LAST_RESET;
`ifdef TRNG_ARB_HEALTH_EN
            retry_cnt     <= '0;
            prev_word     <= '0;
            word_bad      <= 1'b0;
            retry_pending <= 1'b0;
            health_fail_q <= 1'b0;
`endif
        end else begin
            rnd_valid   <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        winner       <= rr_pick;
                        grant        <= NREQ'(1) << rr_pick;
                        trng_request <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // Priority: cancel beats ready, and ready beats timeout
                    if (!req[winner]) begin
                        trng_request <= 1'b0;
                        state        <= RELEASE;
`ifdef TRNG_ARB_HEALTH_EN
                        retry_pending <= 1'b0;
`endif
                    end else if (trng_ready) begin
                        rnd_data     <= trng_random_number;
                        trng_request <= 1'b0;
                        state        <= DELIVER;
`ifdef TRNG_ARB_HEALTH_EN
                        word_bad <= !word_ok;
                        if (word_ok) begin
                            rnd_valid <= grant;
                        end
`else
                        rnd_valid <= grant;
`endif
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        timeout_err  <= 1'b1;
                        trng_request <= 1'b0;
                        state        <= RELEASE;
`ifdef TRNG_ARB_HEALTH_EN
                        retry_pending <= 1'b0;
`endif
                    end
                end
                DELIVER: begin
                    state <= RELEASE;
`ifdef TRNG_ARB_HEALTH_EN
                    if (!word_bad) begin
                        last_winner   <= winner;
                        prev_word     <= rnd_data;
                        retry_cnt     <= '0;
                        retry_pending <= 1'b0;
                    end else if ((32'(retry_cnt) + 1) >= MAX_RETRY) begin
                        health_fail_q <= 1'b1;
                        retry_cnt     <= '0;
                        retry_pending <= 1'b0;
                    end else begin
                        retry_cnt     <= retry_cnt + RW'(1);
                        retry_pending <= 1'b1;
                    end
`else
                    last_winner <= winner;
`endif
                end
                RELEASE: begin
                    if (!trng_ready) begin
`ifdef TRNG_ARB_HEALTH_EN
                        if (retry_pending) begin
                            retry_pending <= 1'b0;
                            trng_request  <= 1'b1;
                            wait_cnt      <= '0;
                            state         <= WAIT_RDY;
                        end else begin
                            grant <= '0;
                            state <= IDLE;
                        end
`else
                        grant <= '0;
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_arbiter.sv
// tb_trng_arbiter: scenario bench for trng_arbiter with a latency-programmable TRNG model
// and a queue of expected deliveries.
`timescale 1ns/1ps
module tb_trng_arbiter;

    localparam int NREQ = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rnd_valid;
    logic [31:0]     rnd_data;
    logic            timeout_err;
    logic            health_fail;
    logic            trng_request;
    logic [31:0]     trng_random_number = '0;
    logic            trng_ready = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0]  v;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] word_q[$];
    int          trng_lat = 32;
    int          trng_cnt = 0;

    trng_arbiter #(.NREQ(NREQ), .TIMEOUT(255), .MAX_RETRY(3)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .grant              (grant),
        .rnd_valid          (rnd_valid),
        .rnd_data           (rnd_data),
        .timeout_err        (timeout_err),
        .health_fail        (health_fail),
        .trng_request       (trng_request),
        .trng_random_number (trng_random_number),
        .trng_ready         (trng_ready)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // TRNG model: raises ready trng_lat cycles after request rises, clears it once request falls
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trng_ready <= 1'b0;
            trng_cnt   <= 0;
        end else if (!trng_request) begin
            trng_ready <= 1'b0;
            trng_cnt   <= 0;
        end else if (!trng_ready && trng_lat > 0) begin
            if (trng_cnt == trng_lat - 1) begin
                trng_ready <= 1'b1;
                if (word_q.size() > 0) trng_random_number <= word_q.pop_front();
                else                   trng_random_number <= 32'hC0DE_0000 + trng_cnt;
            end
            trng_cnt <= trng_cnt + 1;
        end
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_valid(input int max_cycles, output logic [2:0] v, output logic [31:0] d,
                              output logic [2:0] g, output int cycles, output bit tmo);
        v = '0; d = '0; g = '0; cycles = 0; tmo = 1'b1;
        while (cycles < max_cycles) begin
            @(posedge clk); #1;
            cycles++;
            if (rnd_valid != 3'b000) begin
                v = rnd_valid; d = rnd_data; g = grant; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (grant == 3'b000 && trng_request == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_request(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (trng_request == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (grant !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b expected 000", grant); end
        tests_run++;
        if ({rnd_valid, timeout_err, trng_request, health_fail} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got valid=%b tmo=%b req=%b hf=%b expected all 0", rnd_valid, timeout_err, trng_request, health_fail);
        end
        tests_run++;
        if (rnd_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 00000000", rnd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (grant !== 3'b000 || trng_request !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_idle: got grant=%b req=%b expected 000/0", grant, trng_request);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  order [4];
        logic [31:0] v_d;
        logic [2:0]  v_v, v_g;
        int          cyc;
        bit          tmo, ok;
        exp_t        e;
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        trng_lat = 32;
        for (int k = 0; k < 4; k++) begin
            word_q.push_back(32'h1111_0000 + k);
            exp_q.push_back(exp_t'{v: order[k], d: 32'h1111_0000 + k});
        end
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_valid(100, v_v, v_d, v_g, cyc, tmo);
            e = exp_q.pop_front();
            tests_run++;
            if (tmo) begin
                tests_failed++;
                $display("[TB] FAIL rr_timeout_%0d: got no rnd_valid expected %b", k, e.v);
            end else begin
                tests_run++;
                if (v_v !== e.v) begin tests_failed++; $display("[TB] FAIL rr_valid_%0d: got %b expected %b", k, v_v, e.v); end
                tests_run++;
                if (v_d !== e.d) begin tests_failed++; $display("[TB] FAIL rr_data_%0d: got %h expected %h", k, v_d, e.d); end
                tests_run++;
                if (v_g !== e.v) begin tests_failed++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, v_g, e.v); end
            end
        end
        req = 3'b000;
        wait_idle(20, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL rr_idle: got grant=%b expected 000", grant); end
    endtask

    task automatic test_cancel();
        logic [31:0] v_d;
        logic [2:0]  v_v, v_g;
        int          cyc;
        bit          tmo, ok, seen;
        exp_t        e;
        trng_lat = 32;
        req = 3'b001;
        wait_request(10, ok);
        tests_run++;
        if (!ok || grant !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL cancel_grant: got grant=%b req=%b expected 001/1", grant, trng_request);
        end
        repeat (10) @(posedge clk);
        #1;
        req = 3'b000;
        @(posedge clk); #1;
        tests_run++;
        if (trng_request !== 1'b0) begin tests_failed++; $display("[TB] FAIL cancel_request_drop: got %b expected 0", trng_request); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rnd_valid != 3'b000) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("[TB] FAIL cancel_no_valid: got a rnd_valid pulse expected none"); end
        word_q.push_back(32'h2222_0002);
        exp_q.push_back(exp_t'{v: 3'b010, d: 32'h2222_0002});
        req = 3'b011;
        wait_valid(100, v_v, v_d, v_g, cyc, tmo);
        e = exp_q.pop_front();
        req = 3'b000;
        tests_run++;
        if (tmo || v_v !== e.v || v_d !== e.d) begin
            tests_failed++;
            $display("[TB] FAIL cancel_next_rr: got valid=%b data=%h expected %b/%h", v_v, v_d, e.v, e.d);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_single();
        logic [31:0] v_d;
        logic [2:0]  v_v, v_g;
        int          cyc;
        bit          tmo, ok;
        exp_t        e;
        trng_lat = 32;
        word_q.push_back(32'hA5A5_5A5A);
        exp_q.push_back(exp_t'{v: 3'b010, d: 32'hA5A5_5A5A});
        req = 3'b010;
        wait_valid(100, v_v, v_d, v_g, cyc, tmo);
        e = exp_q.pop_front();
        req = 3'b000;
        tests_run++;
        if (tmo || cyc !== 34) begin tests_failed++; $display("[TB] FAIL single_latency: got %0d cycles expected 34", cyc); end
        tests_run++;
        if (v_v !== e.v) begin tests_failed++; $display("[TB] FAIL single_valid: got %b expected %b", v_v, e.v); end
        tests_run++;
        if (v_d !== e.d) begin tests_failed++; $display("[TB] FAIL single_data: got %h expected %h", v_d, e.d); end
        @(posedge clk); #1;
        tests_run++;
        if (rnd_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL single_pulse_width: got %b expected 000", rnd_valid); end
        wait_idle(20, ok);
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok, got, seen;
        logic req_at_tmo;
        trng_lat = 0;
        req = 3'b001;
        wait_request(10, ok);
        cyc = 0; got = 1'b0; seen = 1'b0; req_at_tmo = 1'b1;
        while (cyc < 400 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd_valid != 3'b000) seen = 1'b1;
            if (timeout_err) begin got = 1'b1; req_at_tmo = trng_request; end
        end
        req = 3'b000;
        tests_run++;
        if (!got || cyc !== 255) begin tests_failed++; $display("[TB] FAIL timeout_cycle: got %0d (seen=%0d) expected 255", cyc, got); end
        tests_run++;
        if (req_at_tmo !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_request_drop: got %b expected 0", req_at_tmo); end
        tests_run++;
        if (seen) begin tests_failed++; $display("[TB] FAIL timeout_no_valid: got a rnd_valid pulse expected none"); end
        @(posedge clk); #1;
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_pulse_width: got %b expected 0", timeout_err); end
        wait_idle(20, ok);
        trng_lat = 32;
    endtask

    task automatic test_ready_vs_cancel();
        bit ok, seen, rdy;
        trng_lat = 5;
        req = 3'b001;
        wait_request(10, ok);
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(posedge clk); #1;
            if (trng_ready) rdy = 1'b1;
        end
        req = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rnd_valid != 3'b000) seen = 1'b1;
        end
        tests_run++;
        if (!rdy || seen) begin
            tests_failed++;
            $display("[TB] FAIL ready_vs_cancel: got ready=%0d valid_seen=%0d expected 1/0", rdy, seen);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_ready_vs_timeout();
        int   cyc;
        bit   ok, tmo_seen, got;
        logic [2:0]  v_v;
        logic [31:0] v_d;
        exp_t e;
        trng_lat = 254;
        word_q.push_back(32'h3333_0003);
        exp_q.push_back(exp_t'{v: 3'b001, d: 32'h3333_0003});
        req = 3'b001;
        cyc = 0; tmo_seen = 1'b0; got = 1'b0; v_v = '0; v_d = '0;
        while (cyc < 300 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (timeout_err) tmo_seen = 1'b1;
            if (rnd_valid != 3'b000) begin got = 1'b1; v_v = rnd_valid; v_d = rnd_data; end
        end
        req = 3'b000;
        e = exp_q.pop_front();
        tests_run++;
        if (!got || v_v !== e.v || v_d !== e.d) begin
            tests_failed++;
            $display("[TB] FAIL ready_vs_timeout_delivery: got valid=%b data=%h expected %b/%h", v_v, v_d, e.v, e.d);
        end
        tests_run++;
        if (tmo_seen) begin tests_failed++; $display("[TB] FAIL ready_vs_timeout_err: got timeout_err pulse expected none"); end
        tests_run++;
        if (cyc !== 256) begin tests_failed++; $display("[TB] FAIL ready_vs_timeout_latency: got %0d expected 256", cyc); end
        wait_idle(20, ok);
        trng_lat = 32;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v_d;
        logic [2:0]  v_v, v_g;
        int          cyc;
        bit          tmo, ok;
        exp_t        e;
        trng_lat = 32;
        req = 3'b010;
        wait_request(10, ok);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({grant, rnd_valid, trng_request, timeout_err} !== 8'b0 || rnd_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_outputs: got grant=%b valid=%b req=%b data=%h expected zeros", grant, rnd_valid, trng_request, rnd_data);
        end
        req = 3'b001;
        @(negedge clk);
        rst_n = 1'b1;
        wait_request(10, ok);
        tests_run++;
        if (!ok || grant !== 3'b001) begin tests_failed++; $display("[TB] FAIL reset_mid_regrant: got %b expected 001", grant); end
        word_q.push_back(32'h4444_0004);
        exp_q.push_back(exp_t'{v: 3'b001, d: 32'h4444_0004});
        wait_valid(100, v_v, v_d, v_g, cyc, tmo);
        e = exp_q.pop_front();
        req = 3'b000;
        tests_run++;
        if (tmo || v_v !== e.v || v_d !== e.d) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_delivery: got valid=%b data=%h expected %b/%h", v_v, v_d, e.v, e.d);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  order [3];
        logic [31:0] v_d;
        logic [2:0]  v_v, v_g;
        int          cyc;
        bit          tmo, ok;
        exp_t        e;
        order = '{3'b100, 3'b001, 3'b100};
        trng_lat = 3;
        for (int k = 0; k < 3; k++) begin
            word_q.push_back(32'h5555_0000 + k);
            exp_q.push_back(exp_t'{v: order[k], d: 32'h5555_0000 + k});
        end
        req = 3'b101;
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, v_v, v_d, v_g, cyc, tmo);
            e = exp_q.pop_front();
            tests_run++;
            if (tmo || v_v !== e.v || v_d !== e.d || v_g !== e.v) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d: got valid=%b grant=%b data=%h expected %b/%h", k, v_v, v_g, v_d, e.v, e.d);
            end
        end
        req = 3'b000;
        wait_idle(20, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL b2b_idle: got grant=%b expected 000", grant); end
        trng_lat = 32;
    endtask

    task automatic test_zero_word();
        bit ok;
`ifdef TRNG_ARB_HEALTH_EN
        bit seen, alarm;
        trng_lat = 3;
        for (int k = 0; k < 3; k++) word_q.push_back(32'h0);
        req = 3'b010;
        seen = 1'b0; alarm = 1'b0;
        for (int i = 0; i < 200 && !alarm; i++) begin
            @(posedge clk); #1;
            if (rnd_valid != 3'b000) seen = 1'b1;
            if (health_fail) alarm = 1'b1;
        end
        req = 3'b000;
        tests_run++;
        if (!alarm || seen) begin tests_failed++; $display("[TB] FAIL health_alarm: got hf=%0d valid_seen=%0d expected 1/0", alarm, seen); end
        wait_idle(20, ok);
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (health_fail !== 1'b1) begin tests_failed++; $display("[TB] FAIL health_sticky: got %b expected 1", health_fail); end
`else
        logic [31:0] v_d;
        logic [2:0]  v_v, v_g;
        int          cyc;
        bit          tmo;
        exp_t        e;
        trng_lat = 3;
        word_q.push_back(32'h0);
        exp_q.push_back(exp_t'{v: 3'b010, d: 32'h0});
        req = 3'b010;
        wait_valid(40, v_v, v_d, v_g, cyc, tmo);
        e = exp_q.pop_front();
        req = 3'b000;
        tests_run++;
        if (tmo || v_v !== e.v || v_d !== e.d) begin
            tests_failed++;
            $display("[TB] FAIL zero_word_delivery: got valid=%b data=%h expected %b/%h", v_v, v_d, e.v, e.d);
        end
        tests_run++;
        if (health_fail !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_word_health: got %b expected 0", health_fail); end
        wait_idle(20, ok);
`endif
        trng_lat = 32;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_cancel();
        test_single();
        test_timeout();
        test_ready_vs_cancel();
        test_ready_vs_timeout();
        test_reset_mid();
        test_back_to_back();
        test_zero_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
